button_debouncer: RTL and testbench

Conditions a raw, asynchronous mechanical input (push-button or switch) into a clean, clock-synchronous level plus single-cycle edge pulses. It feeds the D inputs and enables of downstream edge-triggered flip-flop stages, so those stages see no metastable or bouncing data. The block contains a synchronizer chain followed by a 4-state debounce FSM with a stability counter.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/btn_sync.sv | 25 ++
 rtl/button_debouncer.sv | 139 +++++++++++++
 tb/tb_button_debouncer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encodings and default parameters for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 16;
  localparam int unsigned DEF_LONG_CYCLES   = 1024;

endpackage

// File: rtl/btn_sync.sv
// SYNC_STAGES-deep resettable flop chain bringing an asynchronous input into the clk domain.
module btn_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizer plus 4-state debounce FSM producing a clean level and edge pulses.
// Optional held-press detector built only when LONG_PRESS_EN is defined.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
      $error("button_debouncer: illegal parameter value");
    end
  endgenerate

  logic            sync;
  db_state_t       state;
  logic [CNT_W-1:0] cnt;

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          // any bounce discards all accumulated credit
          if (!sync) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE_HIGH;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sync) begin
            state <= WAIT_LOW;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

`ifdef LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt;
  logic              rise_commit;
  logic              fall_commit;

  // Commit conditions decoded from the same terms the FSM uses, so the long
  // counter clears in the cycle btn_rise/btn_fall get registered.
  assign rise_commit = (state == WAIT_HIGH) && sync  && (cnt == CNT_MAX);
  assign fall_commit = (state == WAIT_LOW)  && !sync && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (rise_commit || fall_commit) begin
        long_cnt <= '0;
      end else if (btn_level && (long_cnt != LONG_MAX)) begin
        long_cnt <= long_cnt + 1'b1;
        if (long_cnt == LONG_MAX - 1'b1) begin
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus pushes expected pulse events, a monitor pops them as the DUT pulses.
module tb_button_debouncer;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_LONG = 2;

  typedef struct {
    int kind;
    int edge_no;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, btn_rise, btn_fall, busy, long_press;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  int   c0, c1, c2, c3, c4, c5;

  button_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .busy      (busy),
    .long_press(long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at edge %0d: actual %0d, required %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic push(input int kind, input int edge_no);
    ev_t e;
    e.kind    = kind;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_pulse at edge %0d: actual kind %0d, required no pulse", cyc, kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_edge", cyc, e.edge_no);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"}, btn_level, 0);
    check({name, "_rise"}, btn_rise, 0);
    check({name, "_fall"}, btn_fall, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_long"}, long_press, 0);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      check("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
      if (btn_rise) begin
        got_event(EV_RISE);
        check("rise_level", btn_level, 1);
      end
      if (btn_fall) begin
        got_event(EV_FALL);
        check("fall_level", btn_level, 0);
      end
      if (long_press) begin
        got_event(EV_LONG);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) step();

    // clean press, held long enough for a long press
    c0 = cyc;
    btn_in = 1'b1;
    push(EV_RISE, c0 + 7);
`ifdef LONG_PRESS_EN
    push(EV_LONG, c0 + 15);
`endif
    for (int e = 1; e <= 8; e++) begin
      step();
      check("press_busy", busy, int'(e >= 3 && e <= 6));
      check("press_level", btn_level, int'(e >= 7));
    end
    repeat (12) step();

    // release
    c1 = cyc;
    btn_in = 1'b0;
    push(EV_FALL, c1 + 7);
    repeat (6) step();
    check("release_level_before", btn_level, 1);
    step();
    check("release_level", btn_level, 0);
    repeat (3) step();
    check("release_busy", busy, 0);

    // bounce 1,0,1,0 every 2 cycles, then hold 0
    for (int i = 0; i < 4; i++) begin
      btn_in = (i % 2 == 0);
      repeat (2) step();
    end
    repeat (10) step();
    check("bounce_level", btn_level, 0);
    check("bounce_busy", busy, 0);

    // 4-cycle glitch: filtered
    btn_in = 1'b1;
    repeat (4) step();
    btn_in = 1'b0;
    repeat (10) step();
    check("glitch4_level", btn_level, 0);

    // 5-cycle pulse: qualifies, then releases; too short for long press
    c2 = cyc;
    btn_in = 1'b1;
    push(EV_RISE, c2 + 7);
    push(EV_FALL, c2 + 12);
    repeat (5) step();
    btn_in = 1'b0;
    repeat (12) step();
    check("glitch5_level", btn_level, 0);

    // asynchronous reset while level is high and btn_in stays 1
    c3 = cyc;
    btn_in = 1'b1;
    push(EV_RISE, c3 + 7);
    repeat (10) step();
    check("pre_reset_level", btn_level, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) step();
    reset = 1'b0;
    c4 = cyc;
    push(EV_RISE, c4 + 7);
`ifdef LONG_PRESS_EN
    push(EV_LONG, c4 + 15);
`endif
    repeat (6) step();
    check("post_reset_level_before", btn_level, 0);
    step();
    check("post_reset_level", btn_level, 1);
    repeat (13) step();
    c5 = cyc;
    btn_in = 1'b0;
    push(EV_FALL, c5 + 7);
    repeat (10) step();

    // reset during WAIT_HIGH aborts the pending change
    btn_in = 1'b1;
    repeat (4) step();
    check("wait_busy", busy, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    btn_in = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    check("abort_level", btn_level, 0);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
